imm_encoder: RTL and testbench

- Inverse of the datapath immediate extender. Takes a 32-bit constant and finds a 16-bit immediate plus an EOp mode that the extender expands back to exactly that constant.
- If no single mode fits, it emits a two-word LUI+ORI split.
- Sits in front of the instruction assembler/test-vector generator. Uses valid/ready on both sides and evaluates one mode per clock.

---
 rtl/ext_pkg.sv | 17 +
 rtl/imm_encoder_if.sv | 23 ++
 rtl/imm_encoder_fit.sv | 40 ++++
 rtl/imm_encoder.sv | 179 +++++++++++++++++
 tb/tb_imm_encoder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ext_pkg.sv
// Shared constants for the immediate extender and its inverse encoder:
// EOp codes and the encoder FSM state encoding.
package ext_pkg;

    localparam logic [1:0] EOP_SEXT = 2'b00;
    localparam logic [1:0] EOP_ZEXT = 2'b01;
    localparam logic [1:0] EOP_LUI  = 2'b10;
    localparam logic [1:0] EOP_BR   = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CHECK    = 3'd1;
    localparam logic [2:0] ST_EMIT     = 3'd2;
    localparam logic [2:0] ST_SPLIT_HI = 3'd3;
    localparam logic [2:0] ST_SPLIT_LO = 3'd4;
    localparam logic [2:0] ST_ERR      = 3'd5;

endpackage

// File: rtl/imm_encoder_if.sv
// Constant-in / encoded-word-out handshake bundle of the immediate encoder.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [3:0]  in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    logic        out_err;

    modport master (
        output in_valid, in_value, in_mask, out_ready,
        input  in_ready, out_valid, out_imm, out_eop, out_last, out_err
    );

    modport slave (
        input  in_valid, in_value, in_mask, out_ready,
        output in_ready, out_valid, out_imm, out_eop, out_last, out_err
    );
endinterface

// File: rtl/imm_encoder_fit.sv
// Combinational fit rule for one EOp: does value re-extend exactly from a
// 16-bit immediate under this mode, and if so which immediate.
module imm_fit_check
    import ext_pkg::*;
(
    input  logic [31:0] value,
    input  logic [1:0]  eop,
    output logic        fits,
    output logic [15:0] imm
);

    // Evaluate the selected extension mode against the constant
    always_comb begin
        fits = 1'b0;
        imm  = 16'h0000;
        case (eop)
            EOP_SEXT: begin
                fits = (&value[31:15]) | ~(|value[31:15]);
                imm  = value[15:0];
            end
            EOP_ZEXT: begin
                fits = ~(|value[31:16]);
                imm  = value[15:0];
            end
            EOP_LUI: begin
                fits = ~(|value[15:0]);
                imm  = value[31:16];
            end
            EOP_BR: begin
                fits = ~(|value[1:0]) & ((&value[31:17]) | ~(|value[31:17]));
                imm  = value[17:2];
            end
            default: begin
                fits = 1'b0;
                imm  = 16'h0000;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Finds an immediate/EOp pair that the extender expands to the given constant,
// falling back to a LUI+ORI pair or an error word.
module imm_encoder
    import ext_pkg::*;
#(
    parameter bit ENABLE_SPLIT = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    imm_encoder_if.slave   bus
);

    logic [2:0]  state_r, state_s;
    logic [1:0]  idx_r, idx_s;
    logic [31:0] value_r, value_s;
    logic [3:0]  mask_r, mask_s;
    logic        res_vld_r, res_vld_s;
    logic        res_hit_r, res_hit_s;
    logic [15:0] res_imm_r, res_imm_s;
    logic [1:0]  res_idx_r, res_idx_s;
    logic        ready_r, ready_s;
    logic        valid_r, valid_s;
    logic [15:0] imm_r, imm_s;
    logic [1:0]  eop_r, eop_s;
    logic        last_r, last_s;
    logic        err_r, err_s;
    logic        fit_s;
    logic [15:0] fit_imm_s;

    imm_fit_check u_fit (
        .value (value_r),
        .eop   (idx_r),
        .fits  (fit_s),
        .imm   (fit_imm_s)
    );

    // Next-state logic; each fit result is registered and acted on one cycle later
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        value_s   = value_r;
        mask_s    = mask_r;
        res_vld_s = res_vld_r;
        res_hit_s = res_hit_r;
        res_imm_s = res_imm_r;
        res_idx_s = res_idx_r;
        valid_s   = valid_r;
        imm_s     = imm_r;
        eop_s     = eop_r;
        last_s    = last_r;
        err_s     = err_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_s   = ST_CHECK;
                    value_s   = bus.in_value;
                    mask_s    = bus.in_mask;
                    idx_s     = 2'd0;
                    res_vld_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                res_vld_s = 1'b1;
                res_hit_s = mask_r[idx_r] & fit_s;
                res_imm_s = fit_imm_s;
                res_idx_s = idx_r;
                if (idx_r != 2'd3) begin
                    idx_s = idx_r + 2'd1;
                end else begin
                    idx_s = idx_r;
                end
                if (res_vld_r && res_hit_r) begin
                    state_s   = ST_EMIT;
                    res_vld_s = 1'b0;
                    valid_s   = 1'b1;
                    imm_s     = res_imm_r;
                    eop_s     = res_idx_r;
                    last_s    = 1'b1;
                    err_s     = 1'b0;
                end else if (res_vld_r && (res_idx_r == 2'd3)) begin
                    res_vld_s = 1'b0;
                    valid_s   = 1'b1;
                    if (ENABLE_SPLIT && mask_r[EOP_LUI] && mask_r[EOP_ZEXT]) begin
                        state_s = ST_SPLIT_HI;
                        imm_s   = value_r[31:16];
                        eop_s   = EOP_LUI;
                        last_s  = 1'b0;
                        err_s   = 1'b0;
                    end else begin
                        state_s = ST_ERR;
                        imm_s   = 16'h0000;
                        eop_s   = EOP_SEXT;
                        last_s  = 1'b1;
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_SPLIT_HI: begin
                if (bus.out_ready) begin
                    state_s = ST_SPLIT_LO;
                    imm_s   = value_r[15:0];
                    eop_s   = EOP_ZEXT;
                    last_s  = 1'b1;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_SPLIT_HI;
                end
            end
            ST_EMIT, ST_SPLIT_LO, ST_ERR: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    imm_s   = 16'h0000;
                    eop_s   = EOP_SEXT;
                    last_s  = 1'b0;
                    err_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                imm_s   = 16'h0000;
                eop_s   = EOP_SEXT;
                last_s  = 1'b0;
                err_s   = 1'b0;
            end
        endcase
        ready_s = (state_s == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= 2'd0;
            value_r   <= 32'h0000_0000;
            mask_r    <= 4'h0;
            res_vld_r <= 1'b0;
            res_hit_r <= 1'b0;
            res_imm_r <= 16'h0000;
            res_idx_r <= 2'd0;
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            imm_r     <= 16'h0000;
            eop_r     <= 2'b00;
            last_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            value_r   <= value_s;
            mask_r    <= mask_s;
            res_vld_r <= res_vld_s;
            res_hit_r <= res_hit_s;
            res_imm_r <= res_imm_s;
            res_idx_r <= res_idx_s;
            ready_r   <= ready_s;
            valid_r   <= valid_s;
            imm_r     <= imm_s;
            eop_r     <= eop_s;
            last_r    <= last_s;
            err_r     <= err_s;
        end
    end

    assign bus.in_ready  = ready_r;
    assign bus.out_valid = valid_r;
    assign bus.out_imm   = imm_r;
    assign bus.out_eop   = eop_r;
    assign bus.out_last  = last_r;
    assign bus.out_err   = err_r;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed-vector bench for imm_encoder, with split enabled and disabled.
module tb_imm_encoder;

    logic        clk;
    logic        reset_n;
    logic        sel;
    logic        drv_valid;
    logic        drv_ready;
    logic [31:0] drv_value;
    logic [3:0]  drv_mask;
    int          checks;
    int          failures;
    int          lat;
    int          seen;

    imm_encoder_if bus_a ();
    imm_encoder_if bus_b ();

    imm_encoder #(.ENABLE_SPLIT(1'b1)) dut_split (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    imm_encoder #(.ENABLE_SPLIT(1'b0)) dut_nosplit (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    assign bus_a.in_valid  = drv_valid && !sel;
    assign bus_b.in_valid  = drv_valid && sel;
    assign bus_a.out_ready = drv_ready && !sel;
    assign bus_b.out_ready = drv_ready && sel;
    assign bus_a.in_value  = drv_value;
    assign bus_b.in_value  = drv_value;
    assign bus_a.in_mask   = drv_mask;
    assign bus_b.in_mask   = drv_mask;

    wire        obs_ready = sel ? bus_b.in_ready  : bus_a.in_ready;
    wire        obs_valid = sel ? bus_b.out_valid : bus_a.out_valid;
    wire [15:0] obs_imm   = sel ? bus_b.out_imm   : bus_a.out_imm;
    wire [1:0]  obs_eop   = sel ? bus_b.out_eop   : bus_a.out_eop;
    wire        obs_last  = sel ? bus_b.out_last  : bus_a.out_last;
    wire        obs_err   = sel ? bus_b.out_err   : bus_a.out_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // present one constant, then count cycles from the accept edge to out_valid
    task automatic send(input logic [31:0] value, input logic [3:0] mask, output int latency);
        check("in_ready_before_send", {31'd0, obs_ready}, 32'd1);
        drv_valid = 1'b1;
        drv_value = value;
        drv_mask  = mask;
        cycle();
        drv_valid = 1'b0;
        drv_value = 32'hDEAD_BEEF;
        drv_mask  = 4'h0;
        latency = 0;
        while (!obs_valid && latency < 20) begin
            cycle();
            latency++;
        end
        if (latency >= 20) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic take_word(input string tag, input logic [15:0] imm, input logic [1:0] eop,
                             input logic last, input logic err, input int hold);
        check({tag, "_valid"}, {31'd0, obs_valid}, 32'd1);
        check({tag, "_imm"},   {16'd0, obs_imm},   {16'd0, imm});
        check({tag, "_eop"},   {30'd0, obs_eop},   {30'd0, eop});
        check({tag, "_last"},  {31'd0, obs_last},  {31'd0, last});
        check({tag, "_err"},   {31'd0, obs_err},   {31'd0, err});
        if (hold > 0) begin
            repeat (hold) cycle();
            check({tag, "_held_valid"}, {31'd0, obs_valid}, 32'd1);
            check({tag, "_held_word"}, {12'd0, obs_imm, obs_eop, obs_last, obs_err},
                                       {12'd0, imm, eop, last, err});
        end
        drv_ready = 1'b1;
        cycle();
        drv_ready = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_no_extra_word"}, {31'd0, obs_valid}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, obs_ready}, 32'd1);
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, obs_valid}, 32'd0);
        check({tag, "_ready"}, {31'd0, obs_ready}, 32'd1);
        check({tag, "_word"}, {12'd0, obs_imm, obs_eop, obs_last, obs_err}, 32'd0);
    endtask

    task automatic expect_quiet(input string tag);
        seen = 0;
        repeat (8) begin
            cycle();
            if (obs_valid) seen++;
        end
        check({tag, "_stale_words"}, seen, 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        sel       = 1'b0;
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        drv_value = 32'h0;
        drv_mask  = 4'h0;
        reset_n   = 1'b0;
        repeat (2) cycle();
        expect_reset_outputs("reset_a");
        sel = 1'b1;
        #1;
        expect_reset_outputs("reset_b");
        sel = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        send(32'h0000_0005, 4'b1111, lat);
        check("sext_latency", lat, 32'd2);
        take_word("sext", 16'h0005, 2'b00, 1'b1, 1'b0, 0);
        expect_done("sext");

        send(32'h0000_FFFF, 4'b1111, lat);
        check("zext_latency", lat, 32'd3);
        take_word("zext", 16'hFFFF, 2'b01, 1'b1, 1'b0, 0);
        expect_done("zext");

        send(32'h1234_0000, 4'b1111, lat);
        check("lui_latency", lat, 32'd4);
        take_word("lui", 16'h1234, 2'b10, 1'b1, 1'b0, 0);
        expect_done("lui");

        send(32'h0001_FFFC, 4'b1000, lat);
        check("br_latency", lat, 32'd5);
        take_word("br", 16'h7FFF, 2'b11, 1'b1, 1'b0, 0);
        expect_done("br");

        send(32'h0000_0006, 4'b1000, lat);
        check("err_mask_latency", lat, 32'd5);
        take_word("err_mask", 16'h0000, 2'b00, 1'b1, 1'b1, 0);
        expect_done("err_mask");

        send(32'h1234_5678, 4'b1111, lat);
        check("split_latency", lat, 32'd5);
        take_word("split_hi", 16'h1234, 2'b10, 1'b0, 1'b0, 3);
        take_word("split_lo", 16'h5678, 2'b01, 1'b1, 1'b0, 3);
        expect_done("split");

        sel = 1'b1;
        #1;
        send(32'h1234_5678, 4'b1111, lat);
        take_word("nosplit_err", 16'h0000, 2'b00, 1'b1, 1'b1, 0);
        expect_done("nosplit");
        send(32'hFFFF_8000, 4'b1111, lat);
        check("b2b_latency", lat, 32'd2);
        take_word("b2b", 16'h8000, 2'b00, 1'b1, 1'b0, 0);
        expect_done("b2b");

        sel = 1'b0;
        #1;
        drv_valid = 1'b1;
        drv_value = 32'h1234_5678;
        drv_mask  = 4'b1111;
        cycle();
        drv_valid = 1'b0;
        cycle();
        reset_n = 1'b0;
        #1;
        expect_reset_outputs("rst_in_check");
        @(negedge clk);
        reset_n = 1'b1;
        expect_quiet("rst_in_check");

        send(32'h1234_5678, 4'b1111, lat);
        check("rst_split_hi_word", {16'd0, obs_imm}, 32'h0000_1234);
        reset_n = 1'b0;
        #1;
        expect_reset_outputs("rst_in_split");
        @(negedge clk);
        reset_n = 1'b1;
        expect_quiet("rst_in_split");

        send(32'h1234_0000, 4'b1111, lat);
        check("fresh_latency", lat, 32'd4);
        take_word("fresh", 16'h1234, 2'b10, 1'b1, 1'b0, 0);
        expect_done("fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
